stack_ctrl: RTL and testbench

- Control unit of the stack CPU. Fetches 12-bit instructions from synchronous program memory, decodes them, and drives one-cycle command strobes to the stack/ALU datapath.
- Owns the program counter and the stack-depth counter.
- Detects stack overflow, stack underflow and illegal opcodes, and halts in a sticky fault state.
- Sits between the program ROM loaded by `cpu` and the stack datapath; one instance per `cpu`.

---
 rtl/stack_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stack_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Stack CPU control unit: fetch/decode/execute sequencer owning pc and stack depth.
// Issues one-cycle datapath strobes and stops in a sticky HALT or FAULT state.
module stack_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W+3:0] imem_data,
  input  logic              top_zero,
  output logic [2:0]        dp_cmd,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] dp_imm,
  output logic [SP_W-1:0]   sp,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT} state_t;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_PUSH = 3'd1;
  localparam logic [2:0] CMD_POP  = 3'd2;
  localparam logic [2:0] CMD_ALU  = 3'd3;
  localparam logic [2:0] CMD_DUP  = 3'd4;
  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_UNDER = 2'd1;
  localparam logic [1:0] FC_OVER  = 2'd2;
  localparam logic [1:0] FC_ILL   = 2'd3;
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0]   SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0]   SP_TWO  = SP_W'(2);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] imm_to_addr(input logic [DATA_W-1:0] imm);
    logic [ADDR_W+DATA_W-1:0] ext;
    ext = {{ADDR_W{1'b0}}, imm};
    return ext[ADDR_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [DATA_W+3:0]   ir_q, ir_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [1:0]          alu_q, alu_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic [1:0]          code_q, code_d;

  logic [3:0]          dec_op, exe_op;
  logic [DATA_W-1:0]   dec_imm, exe_imm;
  logic [2:0]          chk_cmd;
  logic [1:0]          chk_code;

  assign dec_op  = imem_data[DATA_W+3:DATA_W];
  assign dec_imm = imem_data[DATA_W-1:0];
  assign exe_op  = ir_q[DATA_W+3:DATA_W];
  assign exe_imm = ir_q[DATA_W-1:0];

  // Legality and stack-depth checks on the word arriving from program memory
  always_comb begin
    chk_cmd  = CMD_NONE;
    chk_code = FC_NONE;
    case (dec_op)
      4'h0, 4'h8, 4'hF: chk_cmd = CMD_NONE;
      4'h1: if (sp_q == SP_FULL) chk_code = FC_OVER; else chk_cmd = CMD_PUSH;
      4'h2, 4'h9: if (sp_q == '0) chk_code = FC_UNDER; else chk_cmd = CMD_POP;
      4'h3, 4'h4, 4'h5, 4'h6: if (sp_q < SP_TWO) chk_code = FC_UNDER; else chk_cmd = CMD_ALU;
      4'h7: begin
        if (sp_q == '0)          chk_code = FC_UNDER;
        else if (sp_q == SP_FULL) chk_code = FC_OVER;
        else                     chk_cmd  = CMD_DUP;
      end
      default: chk_code = FC_ILL;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    ir_d     = ir_q;
    cmd_d    = CMD_NONE;
    alu_d    = alu_q;
    imm_d    = imm_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    code_d   = code_q;
    case (state_q)
      S_FETCH: if (run) state_d = S_DECODE;
      S_DECODE: begin
        ir_d = imem_data;
        if (chk_code != FC_NONE) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = chk_code;
        end else begin
          state_d = S_EXEC;
          cmd_d   = chk_cmd;
          if (chk_cmd == CMD_PUSH) imm_d = dec_imm;
          if (chk_cmd == CMD_ALU)  alu_d = dec_op[1:0] - 2'd3;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_ONE;
        case (exe_op)
          4'h1, 4'h7: sp_d = sp_q + SP_ONE;
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6: sp_d = sp_q - SP_ONE;
          4'h8: pc_d = imm_to_addr(exe_imm);
          4'h9: begin
            sp_d = sp_q - SP_ONE;
            if (top_zero) pc_d = imm_to_addr(exe_imm);
          end
          4'hF: begin
            pc_d     = pc_q;
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: pc_d = pc_q + PC_ONE;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      sp_q     <= '0;
      cmd_q    <= CMD_NONE;
      alu_q    <= '0;
      imm_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      cmd_q    <= cmd_d;
      alu_q    <= alu_d;
      imm_q    <= imm_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  // The instruction register is rewritten in every DECODE before EXEC reads it
  always_ff @(posedge clk) begin
    ir_q <= ir_d;
  end

  assign imem_addr  = pc_q;
  assign dp_cmd     = cmd_q;
  assign alu_op     = alu_q;
  assign dp_imm     = imm_q;
  assign sp         = sp_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random programs checked against an
// instruction-level model that keeps the stack contents in a queue.
`timescale 1ns/1ps
module tb_stack_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int SP_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, run, top_zero;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W+3:0] imem_data;
  logic [2:0]        dp_cmd;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] dp_imm;
  logic [SP_W-1:0]   sp;
  logic              halted, fault;
  logic [1:0]        fault_code;
  logic [11:0]       mem [256];
  int                checks = 0;
  int                errors = 0;

  stack_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .top_zero(top_zero), .dp_cmd(dp_cmd), .alu_op(alu_op), .dp_imm(dp_imm), .sp(sp),
    .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fill(input logic [11:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
  endtask

  // Leaves the bench in cycle 1: first cycle after the reset edge, rst low, run high
  task automatic do_reset();
    rst = 1'b1; run = 1'b1; top_zero = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [11:0] rand_instr();
    int unsigned r;
    logic [3:0] op;
    logic [7:0] imm;
    r   = $urandom_range(0, 99);
    imm = 8'($urandom_range(0, 255));
    if (r < 10)      op = 4'h0;
    else if (r < 38) op = 4'h1;
    else if (r < 48) op = 4'h2;
    else if (r < 62) op = 4'(3 + $urandom_range(0, 3));
    else if (r < 70) op = 4'h7;
    else if (r < 76) op = 4'h8;
    else if (r < 92) op = 4'h9;
    else if (r < 95) op = 4'hF;
    else             op = 4'(10 + $urandom_range(0, 4));
    if (op == 4'h1) imm = 8'($urandom_range(0, 2));
    return {op, imm};
  endfunction

  task automatic test_reset();
    load_fill(12'h000);
    do_reset();
    checks++; if (dp_cmd !== 3'd0) begin errors++; $display("FAIL reset_dp_cmd got %0d exp 0", dp_cmd); end
    checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", imem_addr); end
    checks++; if (sp !== 5'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", sp); end
    checks++; if (alu_op !== 2'd0 || dp_imm !== 8'd0) begin errors++; $display("FAIL reset_alu_imm got %0d/%0d exp 0/0", alu_op, dp_imm); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0) begin errors++; $display("FAIL reset_flags got %0d/%0d/%0d exp 0/0/0", halted, fault, fault_code); end
  endtask

  task automatic test_program();
    logic [2:0] exp_cmd;
    load_fill(12'hF00);
    mem[0] = 12'h105; mem[1] = 12'h103; mem[2] = 12'h300; mem[3] = 12'hF00;
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      exp_cmd = (c == 3 || c == 6) ? 3'd1 : (c == 9) ? 3'd3 : 3'd0;
      checks++; if (dp_cmd !== exp_cmd) begin errors++; $display("FAIL prog_cmd c%0d got %0d exp %0d", c, dp_cmd, exp_cmd); end
      if (c == 3 || c == 6) begin
        checks++; if (dp_imm !== ((c == 3) ? 8'd5 : 8'd3)) begin errors++; $display("FAIL prog_imm c%0d got %0d", c, dp_imm); end
      end
      if (c == 9) begin
        checks++; if (alu_op !== 2'd0) begin errors++; $display("FAIL prog_alu got %0d exp 0", alu_op); end
      end
      if (c == 4 || c == 7 || c == 10) begin
        checks++; if (sp !== ((c == 7) ? 5'd2 : 5'd1)) begin errors++; $display("FAIL prog_sp c%0d got %0d", c, sp); end
      end
      checks++; if (halted !== (c >= 13)) begin errors++; $display("FAIL prog_halted c%0d got %0d exp %0d", c, halted, c >= 13); end
      tick();
    end
    checks++; if (imem_addr !== 8'd3) begin errors++; $display("FAIL prog_halt_pc got %0d exp 3", imem_addr); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (halted !== 1'b0 || sp !== 5'd0 || imem_addr !== 8'd0) begin errors++; $display("FAIL prog_rst_halt got %0d/%0d/%0d exp 0/0/0", halted, sp, imem_addr); end
  endtask

  task automatic test_underflow();
    load_fill(12'h000);
    mem[5] = 12'h200;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      checks++; if (dp_cmd !== 3'd0) begin errors++; $display("FAIL unf_strobe c%0d got %0d exp 0", c, dp_cmd); end
      checks++; if (fault !== (c >= 18)) begin errors++; $display("FAIL unf_fault c%0d got %0d exp %0d", c, fault, c >= 18); end
      if (c >= 18) begin
        checks++; if (fault_code !== 2'd1 || imem_addr !== 8'd5 || sp !== 5'd0) begin errors++; $display("FAIL unf_hold c%0d got code %0d pc %0d sp %0d exp 1/5/0", c, fault_code, imem_addr, sp); end
      end
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (fault !== 1'b0 || fault_code !== 2'd0 || imem_addr !== 8'd0) begin errors++; $display("FAIL unf_rst got %0d/%0d/%0d exp 0/0/0", fault, fault_code, imem_addr); end
  endtask

  task automatic test_overflow();
    int pushes = 0;
    logic [2:0] exp_cmd;
    load_fill(12'hF00);
    for (int i = 0; i <= 16; i++) mem[i] = {4'h1, 8'($urandom_range(0, 255))};
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      exp_cmd = (c % 3 == 0 && c <= 48) ? 3'd1 : 3'd0;
      checks++; if (dp_cmd !== exp_cmd) begin errors++; $display("FAIL ovf_cmd c%0d got %0d exp %0d", c, dp_cmd, exp_cmd); end
      if (dp_cmd === 3'd1) begin
        pushes++;
        checks++; if (dp_imm !== mem[c / 3 - 1][7:0]) begin errors++; $display("FAIL ovf_imm c%0d got %0d exp %0d", c, dp_imm, mem[c / 3 - 1][7:0]); end
      end
      if (c == 49) begin
        checks++; if (sp !== 5'd16) begin errors++; $display("FAIL ovf_full got %0d exp 16", sp); end
      end
      tick();
    end
    checks++; if (pushes != 16) begin errors++; $display("FAIL ovf_push_count got %0d exp 16", pushes); end
    checks++; if (fault !== 1'b1 || fault_code !== 2'd2) begin errors++; $display("FAIL ovf_code got %0d/%0d exp 1/2", fault, fault_code); end
    checks++; if (sp !== 5'd16 || imem_addr !== 8'd16) begin errors++; $display("FAIL ovf_hold got sp %0d pc %0d exp 16/16", sp, imem_addr); end
  endtask

  task automatic test_jz();
    load_fill(12'hF00);
    mem[0] = 12'h100; mem[1] = 12'h940; mem[8'h40] = 12'h101; mem[8'h41] = 12'h940;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      top_zero = (c == 6 || c == 11);
      if (c == 6 || c == 12) begin
        checks++; if (dp_cmd !== 3'd2) begin errors++; $display("FAIL jz_pop c%0d got %0d exp 2", c, dp_cmd); end
      end
      if (c == 4 || c == 10) begin
        checks++; if (sp !== 5'd1) begin errors++; $display("FAIL jz_sp_push c%0d got %0d exp 1", c, sp); end
      end
      if (c == 7) begin
        checks++; if (imem_addr !== 8'h40 || sp !== 5'd0) begin errors++; $display("FAIL jz_taken got pc %0d sp %0d exp 64/0", imem_addr, sp); end
      end
      if (c == 13) begin
        checks++; if (imem_addr !== 8'h42 || sp !== 5'd0) begin errors++; $display("FAIL jz_not_taken got pc %0d sp %0d exp 66/0", imem_addr, sp); end
      end
      tick();
    end
    top_zero = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL jz_halt got %0d exp 1", halted); end
  endtask

  task automatic test_wrap_stall();
    load_fill(12'hF00);
    mem[0] = 12'h8FF; mem[255] = 12'h000;
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      run = !(c >= 7 && c <= 11);
      checks++; if (dp_cmd !== 3'd0) begin errors++; $display("FAIL wrap_strobe c%0d got %0d exp 0", c, dp_cmd); end
      if (c == 4 || c == 15) begin
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_jmp c%0d got %0d exp 255", c, imem_addr); end
      end
      if (c >= 7 && c <= 14) begin
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_stall c%0d got %0d exp 0", c, imem_addr); end
      end
      tick();
    end
    run = 1'b1;
  endtask

  task automatic test_illegal_rst();
    load_fill(12'hF00);
    mem[0] = 12'hB00;
    do_reset();
    tick(); tick();
    for (int c = 3; c <= 5; c++) begin
      checks++; if (fault !== 1'b1 || fault_code !== 2'd3 || dp_cmd !== 3'd0) begin errors++; $display("FAIL ill_code c%0d got %0d/%0d/%0d exp 1/3/0", c, fault, fault_code, dp_cmd); end
      tick();
    end
    mem[0] = 12'h101; mem[1] = 12'h102; mem[2] = 12'h300;
    do_reset();
    for (int c = 1; c < 9; c++) tick();
    checks++; if (dp_cmd !== 3'd3 || sp !== 5'd2) begin errors++; $display("FAIL rst_exec_pre got cmd %0d sp %0d exp 3/2", dp_cmd, sp); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (dp_cmd !== 3'd0 || sp !== 5'd0 || imem_addr !== 8'd0 || fault !== 1'b0) begin errors++; $display("FAIL rst_exec_post got cmd %0d sp %0d pc %0d fault %0d exp 0/0/0/0", dp_cmd, sp, imem_addr, fault); end
    tick(); tick();
    checks++; if (dp_cmd !== 3'd1 || dp_imm !== 8'd1) begin errors++; $display("FAIL rst_restart got cmd %0d imm %0d exp 1/1", dp_cmd, dp_imm); end
  endtask

  task automatic test_random(input int nprog);
    int q[$];
    int m_pc, stall, a, b, r;
    logic [3:0] op;
    logic [7:0] imm;
    logic [2:0] exp_cmd;
    logic [1:0] exp_code;
    logic tz;
    bit done;
    for (int p = 0; p < nprog; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_instr();
      do_reset();
      q.delete(); m_pc = 0; done = 0;
      for (int n = 0; n < 40 && !done; n++) begin
        op = mem[m_pc][11:8]; imm = mem[m_pc][7:0];
        exp_code = 2'd0; exp_cmd = 3'd0;
        case (op)
          4'h1: if (q.size() == DEPTH) exp_code = 2'd2; else exp_cmd = 3'd1;
          4'h2, 4'h9: if (q.size() == 0) exp_code = 2'd1; else exp_cmd = 3'd2;
          4'h3, 4'h4, 4'h5, 4'h6: if (q.size() < 2) exp_code = 2'd1; else exp_cmd = 3'd3;
          4'h7: if (q.size() == 0) exp_code = 2'd1; else if (q.size() == DEPTH) exp_code = 2'd2; else exp_cmd = 3'd4;
          4'hA, 4'hB, 4'hC, 4'hD, 4'hE: exp_code = 2'd3;
          default: exp_cmd = 3'd0;
        endcase
        stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        top_zero = 1'($urandom_range(0, 1));
        checks++; if (int'(imem_addr) != m_pc || dp_cmd !== 3'd0) begin errors++; $display("FAIL rnd_fetch got pc %0d cmd %0d exp %0d/0", imem_addr, dp_cmd, m_pc); end
        for (int s = 0; s < stall; s++) begin
          run = 1'b0; tick();
          checks++; if (int'(imem_addr) != m_pc || dp_cmd !== 3'd0) begin errors++; $display("FAIL rnd_stall got pc %0d cmd %0d exp %0d/0", imem_addr, dp_cmd, m_pc); end
        end
        run = 1'b1; tick();
        run = 1'($urandom_range(0, 1)); top_zero = 1'($urandom_range(0, 1));
        checks++; if (dp_cmd !== 3'd0) begin errors++; $display("FAIL rnd_decode_cmd got %0d exp 0", dp_cmd); end
        tick();
        run = 1'($urandom_range(0, 1));
        if (exp_code != 2'd0) begin
          checks++; if (fault !== 1'b1 || fault_code !== exp_code || dp_cmd !== 3'd0) begin errors++; $display("FAIL rnd_fault got %0d/%0d/%0d exp 1/%0d/0", fault, fault_code, dp_cmd, exp_code); end
          done = 1;
        end else begin
          tz = (q.size() > 0) && (q[$] == 0);
          top_zero = tz;
          checks++; if (dp_cmd !== exp_cmd) begin errors++; $display("FAIL rnd_cmd op %0d got %0d exp %0d", op, dp_cmd, exp_cmd); end
          if (op == 4'h1) begin
            checks++; if (dp_imm !== imm) begin errors++; $display("FAIL rnd_imm got %0d exp %0d", dp_imm, imm); end
          end
          if (exp_cmd == 3'd3) begin
            checks++; if (int'(alu_op) != int'(op) - 3) begin errors++; $display("FAIL rnd_alu got %0d exp %0d", alu_op, int'(op) - 3); end
          end
          case (op)
            4'h1: q.push_back(int'(imm));
            4'h2, 4'h9: void'(q.pop_back());
            4'h3, 4'h4, 4'h5, 4'h6: begin
              b = q.pop_back(); a = q.pop_back();
              r = (op == 4'h3) ? a + b : (op == 4'h4) ? a - b : (op == 4'h5) ? (a & b) : (a | b);
              q.push_back(r & 255);
            end
            4'h7: q.push_back(q[$]);
            default: r = 0;
          endcase
          if (op == 4'h8 || (op == 4'h9 && tz)) m_pc = int'(imm);
          else if (op != 4'hF) m_pc = (m_pc + 1) % 256;
          tick();
          checks++; if (int'(sp) != q.size()) begin errors++; $display("FAIL rnd_sp op %0d got %0d exp %0d", op, sp, q.size()); end
          checks++; if (halted !== (op == 4'hF) || fault !== 1'b0) begin errors++; $display("FAIL rnd_halt got %0d/%0d exp %0d/0", halted, fault, op == 4'hF); end
          if (op == 4'hF) done = 1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; top_zero = 1'b0;
    test_reset();
    test_program();
    test_underflow();
    test_overflow();
    test_jz();
    test_wrap_stall();
    test_illegal_rst();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
